wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter sitting directly upstream of the register file write port. Merges the in-order pipeline writeback stream (no backpressure) with out-of-order results from the multi-cycle mult/div unit (valid/ready handshake, buffered in a small FIFO). Drives registered `ctrl_writeEnable` / `ctrl_writeReg` / `data_writeReg` into the register file. Exports a pending-destination mask for the hazard unit and a starvation stall to the pipeline.

## Interface
- `DEPTH`, 4: mult/div result FIFO entries (power of two, 2..16).
- `STARVE_LIMIT`, 3: consecutive cycles a non-empty FIFO head may lose arbitration before `pipe_stall` asserts.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `ctrl_reset_n`  in  1  asynchronous, active-low reset.
- `pipe_valid`  in  1  the MW latch holds a register write this cycle.
- `pipe_rd`  in  5  pipeline destination register.
- `pipe_data`  in  32  pipeline write data.
- `md_valid`  in  1  mult/div result offered.
- `md_ready`  out  1  arbiter accepts the mult/div result this cycle.
- `md_rd`  in  5  mult/div destination register.
- `md_data`  in  32  mult/div result.
- `pipe_stall`  out  1  pipeline must hold its MW latch; `pipe_valid` is ignored this cycle.
- `busy_mask`  out  32  one-hot OR of destinations queued in the FIFO; bit 0 is always 0.
- `fifo_count`  out  $clog2(DEPTH)+1  number of FIFO entries.
- `ctrl_writeEnable`  out  1  register file write enable (registered).
- `ctrl_writeReg`  out  5  register file write index (registered).
- `data_writeReg`  out  32  register file write data (registered).

## Operation
- Handshake:
  - `md_ready = (fifo_count != DEPTH)`. This depends on state only and never on `md_valid`.
  - A transfer occurs when `md_valid && md_ready`.
  - A transfer with `md_rd == 0` is accepted and discarded, so it is never enqueued.
- Starvation:
  - `age` counter: cleared on pop, on empty FIFO, and on reset.
  - `age` increments, saturating at `STARVE_LIMIT`, each cycle the FIFO is non-empty and the head is not popped.
  - `pipe_stall = (age == STARVE_LIMIT)`.
- Arbitration, evaluated each cycle in this order:
  1. If `pipe_stall`: pop the FIFO head and issue it.
  2. Else if `pipe_valid && pipe_rd != 0`: issue the pipeline write. The FIFO does not pop.
  3. Else if the FIFO is non-empty: pop the head and issue it.
  4. Else: issue nothing. `ctrl_writeEnable` is 0 next cycle.
- `pipe_valid` with `pipe_rd == 0` issues nothing, and the FIFO head may use that slot.
- Simultaneous push and pop are legal at any count, including full. At full, push is blocked by `md_ready = 0` even if a pop occurs the same cycle.
- Empty FIFO with a push in the same cycle: the new entry is not bypassed; it is issued no earlier than the next cycle.
- FIFO order is strict first-in, first-out. Read and write pointers wrap modulo `DEPTH`.
- `busy_mask` is combinational from the FIFO contents. It includes the head until the cycle it pops.
- The hazard unit guarantees no write-after-write conflict between `pipe_rd` and `busy_mask`. This block does not reorder for it.

## Timing
- Reset (asynchronous, `ctrl_reset_n` low):
  - `ctrl_writeEnable = 0`, `ctrl_writeReg = 0`, `data_writeReg = 0`.
  - `fifo_count = 0`, `age = 0`, pointers = 0.
  - `md_ready = 1` and `pipe_stall = 0` once reset is released. Both are driven 0 while reset is held.
- Reset asserted mid-operation drops all queued entries and any in-flight write.
- Latency:
  - Pipeline write: 1 cycle from `pipe_valid` to the write outputs. The register file commits on the following edge.
  - Mult/div write: at least 2 cycles from handshake to the write outputs (enqueue, then pop).
- `pipe_stall` asserts in the cycle after the `STARVE_LIMIT`-th lost arbitration. It deasserts the cycle after the pop.
- Throughput: one register file write per cycle maximum.

## Structure
- Shared package `wb_pkg`:
  - `REG_IDX_W = 5`, `DATA_W = 32`, `NUM_REGS = 32`.
  - Entry typedef `{rd[4:0], data[31:0]}`.
- Sub-module `wb_fifo`: parameterized synchronous FIFO with `push`, `pop`, `head`, `count`, and the entry array exposed for the mask.
- Reuse the existing `decoder5to32` once per FIFO entry to build `busy_mask`, ORed across valid entries with bit 0 forced to 0.
- Arbiter, `age` counter and output registers live in `wb_arbiter`.

## Test plan
- Reset, then `pipe_valid = 1`, `pipe_rd = 5`, `pipe_data = 0xDEADBEEF` -> next cycle `ctrl_writeEnable = 1`, `ctrl_writeReg = 5`, `data_writeReg = 0xDEADBEEF`.
- `md_valid` with `md_rd = 7`, `md_data = 42` while the pipeline is idle -> `busy_mask[7] = 1` for one cycle; write of 42 to r7 appears 2 cycles after the handshake; `busy_mask` returns to 0.
- Push 4 mult/div results with `pipe_valid` held high (`rd = 3`) -> `md_ready = 0` at `fifo_count = 4`; after 3 lost cycles `pipe_stall = 1`; the head drains; pipeline writes resume after deassertion; no data lost.
- `md_rd = 0` and `pipe_rd = 0` offered -> `md_ready = 1`, `fifo_count` unchanged, `ctrl_writeEnable = 0`.
- Full FIFO, simultaneous pop and `md_valid` -> no push (`md_ready = 0`); `fifo_count` goes 4 -> 3; next cycle the push is accepted and pointers wrap correctly.
- 3 queued entries, assert `ctrl_reset_n = 0` mid-cycle -> outputs are 0 immediately, `fifo_count = 0`, `busy_mask = 0`, no write after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter slice.
// Contents:
//   REG_IDX_W / DATA_W / NUM_REGS - register file geometry
//   wb_entry_t                    - one queued mult/div result {rd, data}
package wb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/decoder5to32.sv
// 5-to-32 one-hot decoder, shared with the hazard logic.
// Ports:
//   i_idx    - register index
//   o_onehot - bit i_idx set, all others clear
module decoder5to32 (
    input  logic [4:0]  i_idx,
    output logic [31:0] o_onehot
);

    assign o_onehot = 32'd1 << i_idx;

endmodule

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding mult/div results until they win the write port.
// Ports:
//   clock, ctrl_reset_n - clock, async active-low reset
//   i_push, i_din       - enqueue i_din (caller guarantees not full)
//   i_pop               - dequeue head (caller guarantees not empty)
//   o_head              - oldest entry
//   o_count             - number of stored entries
//   o_entryRd/o_valid   - per-slot destination and occupancy, for the busy mask
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                clock,
    input  logic                                ctrl_reset_n,
    input  logic                                i_push,
    input  logic                                i_pop,
    input  wb_entry_t                           i_din,
    output wb_entry_t                           o_head,
    output logic [$clog2(DEPTH):0]              o_count,
    output logic [DEPTH-1:0][REG_IDX_W-1:0]     o_entryRd,
    output logic [DEPTH-1:0]                    o_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0]  r_mem;
    logic [DEPTH-1:0]       r_valid;
    logic [PTR_W-1:0]       r_wrPtr;
    logic [PTR_W-1:0]       r_rdPtr;
    logic [CNT_W-1:0]       r_count;

    // Pointers wrap naturally because DEPTH is a power of two. A slot's
    // valid bit tracks occupancy so the mask never needs pointer arithmetic.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_mem   <= '0;
            r_valid <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wrPtr]   <= i_din;
                r_valid[r_wrPtr] <= 1'b1;
                r_wrPtr          <= r_wrPtr + PTR_W'(1);
            end
            if (i_pop) begin
                r_valid[r_rdPtr] <= 1'b0;
                r_rdPtr          <= r_rdPtr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_entryRd[i] = r_mem[i].rd;
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;
    assign o_valid = r_valid;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter in front of the register file write port. Merges the
// in-order pipeline writeback (no backpressure) with buffered mult/div
// results, and stalls the pipeline when the buffered head starves.
// Ports:
//   clock, ctrl_reset_n                  - clock, async active-low reset
//   pipe_valid/pipe_rd/pipe_data         - pipeline writeback request
//   pipe_stall                           - pipeline must hold its MW latch
//   md_valid/md_ready/md_rd/md_data      - mult/div result handshake
//   busy_mask                            - destinations queued in the FIFO
//   fifo_count                           - FIFO occupancy
//   ctrl_writeEnable/ctrl_writeReg/
//   data_writeReg                        - registered register file write
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                        clock,
    input  logic                        ctrl_reset_n,
    input  logic                        pipe_valid,
    input  logic [REG_IDX_W-1:0]        pipe_rd,
    input  logic [DATA_W-1:0]           pipe_data,
    input  logic                        md_valid,
    output logic                        md_ready,
    input  logic [REG_IDX_W-1:0]        md_rd,
    input  logic [DATA_W-1:0]           md_data,
    output logic                        pipe_stall,
    output logic [NUM_REGS-1:0]         busy_mask,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic                        ctrl_writeEnable,
    output logic [REG_IDX_W-1:0]        ctrl_writeReg,
    output logic [DATA_W-1:0]           data_writeReg
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0]               r_age;
    logic                           r_we;
    logic [REG_IDX_W-1:0]           r_wrReg;
    logic [DATA_W-1:0]              r_wrData;

    wb_entry_t                      w_head;
    wb_entry_t                      w_din;
    logic [CNT_W-1:0]               w_count;
    logic [DEPTH-1:0][REG_IDX_W-1:0] w_entryRd;
    logic [DEPTH-1:0]               w_entryValid;
    logic                           w_fifoEmpty;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_pipeIssue;
    logic [NUM_REGS-1:0]            w_onehot [DEPTH];
    logic [NUM_REGS-1:0]            w_maskOr;

    assign w_fifoEmpty = (w_count == '0);

    // Both handshake-side outputs are forced low while reset is held.
    assign md_ready   = ctrl_reset_n && (w_count != FULL_CNT);
    assign pipe_stall = ctrl_reset_n && (r_age == AGE_MAX);

    // Results targeting r0 are acknowledged but never stored.
    assign w_push = md_valid && md_ready && (md_rd != '0);
    assign w_din  = '{rd: md_rd, data: md_data};

    // Priority: starving head, then pipeline, then FIFO head in a free slot.
    // A stall implies a non-empty FIFO since age only grows while occupied.
    assign w_pipeIssue = !pipe_stall && pipe_valid && (pipe_rd != '0);
    assign w_pop       = !w_fifoEmpty && (pipe_stall || !w_pipeIssue);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_din        (w_din),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_entryRd    (w_entryRd),
        .o_valid      (w_entryValid)
    );

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_dec
            decoder5to32 u_dec (
                .i_idx    (w_entryRd[g]),
                .o_onehot (w_onehot[g])
            );
        end
    endgenerate

    always_comb begin
        w_maskOr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entryValid[i]) begin
                w_maskOr = w_maskOr | w_onehot[i];
            end
        end
    end

    assign busy_mask  = w_maskOr & ~NUM_REGS'(1);
    assign fifo_count = w_count;

    // Age counts consecutive lost cycles of the current head; write port
    // holds its last index/data when idle, only the enable drops.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_age    <= '0;
            r_we     <= 1'b0;
            r_wrReg  <= '0;
            r_wrData <= '0;
        end else begin
            if (w_fifoEmpty || w_pop) begin
                r_age <= '0;
            end else if (r_age != AGE_MAX) begin
                r_age <= r_age + AGE_W'(1);
            end
            r_we <= w_pipeIssue || w_pop;
            if (w_pipeIssue) begin
                r_wrReg  <= pipe_rd;
                r_wrData <= pipe_data;
            end else if (w_pop) begin
                r_wrReg  <= w_head.rd;
                r_wrData <= w_head.data;
            end
        end
    end

    assign ctrl_writeEnable = r_we;
    assign ctrl_writeReg    = r_wrReg;
    assign data_writeReg    = r_wrData;

endmodule
